// File: rtl/recirc_merge.sv
// recirc_merge: per-lane merge of recirculated and buffered ingress words with IDL generation (optional RECIRC_CNT_EN counters)
module recirc_merge #(
    parameter int FIFO_DEPTH  = 4,
    parameter int IDLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic [7:0] in_data2,
    input  logic [7:0] in_data3,
    input  logic       in_valid0,
    input  logic       in_valid1,
    input  logic       in_valid2,
    input  logic       in_valid3,
    input  logic [7:0] rc_data0,
    input  logic [7:0] rc_data1,
    input  logic [7:0] rc_data2,
    input  logic [7:0] rc_data3,
    input  logic       rc_valid0,
    input  logic       rc_valid1,
    input  logic       rc_valid2,
    input  logic       rc_valid3,
    output logic [7:0] out_data0,
    output logic [7:0] out_data1,
    output logic [7:0] out_data2,
    output logic [7:0] out_data3,
    output logic       out_valid0,
    output logic       out_valid1,
    output logic       out_valid2,
    output logic       out_valid3,
    output logic       IDL,
    output logic [3:0] ovf,
    output logic [7:0] rc_count0,
    output logic [7:0] rc_count1,
    output logic [7:0] rc_count2,
    output logic [7:0] rc_count3
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [3:0] IC = 4'(IDLE_CYCLES);

    logic [7:0] w_in_d [4];
    logic [7:0] w_rc_d [4];
    logic [7:0] w_od [4];
    logic [7:0] w_rc_cnt [4];
    logic [3:0] w_in_v, w_rc_v, w_empty, w_ov, w_ovf;
    logic       w_quiet;
    logic [3:0] r_idle;
    logic       r_idl;

    assign w_in_d = '{in_data0, in_data1, in_data2, in_data3};
    assign w_rc_d = '{rc_data0, rc_data1, rc_data2, rc_data3};
    assign w_in_v = {in_valid3, in_valid2, in_valid1, in_valid0};
    assign w_rc_v = {rc_valid3, rc_valid2, rc_valid1, rc_valid0};

    for (genvar n = 0; n < 4; n++) begin : g_lane
        logic [7:0]    r_mem [FIFO_DEPTH];
        logic [AW-1:0] r_wp, r_rp;
        logic [CW-1:0] r_cnt;
        logic [7:0]    r_od;
        logic          r_ov, r_ovf;
        logic          w_full, w_pop, w_push;

        assign w_empty[n] = r_cnt == '0;
        assign w_full     = r_cnt == FULL;
        assign w_pop      = !w_rc_v[n] && !w_empty[n];
        // Buffer unless bypassing; a full FIFO only accepts when it pops this cycle
        assign w_push     = w_in_v[n] && (w_rc_v[n] || !w_empty[n]) && (!w_full || w_pop);

        // FIFO storage; contents are don't-care once pointers are cleared
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wp] <= w_in_d[n];
        end

        // Pointers, occupancy, merged output and sticky overflow
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                r_od  <= '0;
                r_ov  <= 1'b0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push) r_wp <= r_wp + AW'(1);
                if (w_pop) r_rp <= r_rp + AW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
                r_ov  <= w_rc_v[n] || !w_empty[n] || w_in_v[n];
                if (w_rc_v[n]) r_od <= w_rc_d[n];
                else if (!w_empty[n]) r_od <= r_mem[r_rp];
                else if (w_in_v[n]) r_od <= w_in_d[n];
                if (w_in_v[n] && w_rc_v[n] && w_full) r_ovf <= 1'b1;
            end
        end

        assign w_od[n]  = r_od;
        assign w_ov[n]  = r_ov;
        assign w_ovf[n] = r_ovf;

`ifdef RECIRC_CNT_EN
        logic [7:0] r_rc_cnt;
        // Saturating count of recirculated words on this lane
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) r_rc_cnt <= '0;
            else if (w_rc_v[n] && r_rc_cnt != 8'hFF) r_rc_cnt <= r_rc_cnt + 8'd1;
        end
        assign w_rc_cnt[n] = r_rc_cnt;
`else
        assign w_rc_cnt[n] = 8'd0;
`endif
    end

    assign w_quiet = w_in_v == 4'd0 && &w_empty;

    // Quiet-cycle run length and IDL; recirculated traffic does not count as activity
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_idle <= '0;
            r_idl  <= 1'b0;
        end else begin
            r_idle <= !w_quiet ? 4'd0 : (r_idle < IC ? r_idle + 4'd1 : r_idle);
            r_idl  <= w_quiet && r_idle >= IC - 4'd1;
        end
    end

    assign out_data0  = w_od[0];
    assign out_data1  = w_od[1];
    assign out_data2  = w_od[2];
    assign out_data3  = w_od[3];
    assign out_valid0 = w_ov[0];
    assign out_valid1 = w_ov[1];
    assign out_valid2 = w_ov[2];
    assign out_valid3 = w_ov[3];
    assign ovf        = w_ovf;
    assign IDL        = r_idl;
    assign rc_count0  = w_rc_cnt[0];
    assign rc_count1  = w_rc_cnt[1];
    assign rc_count2  = w_rc_cnt[2];
    assign rc_count3  = w_rc_cnt[3];
endmodule

// File: tb/tb_recirc_merge.sv
// tb_recirc_merge: directed and randomized checks of recirc_merge against a queue-based lane model
module tb_recirc_merge;
    localparam int DEPTH = 4;
    localparam int IDLE  = 3;

    logic        clk = 1'b0;
    logic        reset_L = 1'b1;
    logic [31:0] in_d, rc_d;
    logic [3:0]  in_v, rc_v;
    wire  [31:0] od, rcc;
    wire  [3:0]  ov, ovf;
    wire         IDL;

    int npass = 0;
    int ntotal = 0;

    logic [7:0] mq [4][$];
    logic [7:0] m_od [4];
    logic [3:0] m_ov, m_ovf;
    logic       m_idl;
    int         m_run;
    int         m_rc [4];

    recirc_merge #(.FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE)) dut (
        .clk(clk), .reset_L(reset_L),
        .in_data0(in_d[7:0]), .in_data1(in_d[15:8]), .in_data2(in_d[23:16]), .in_data3(in_d[31:24]),
        .in_valid0(in_v[0]), .in_valid1(in_v[1]), .in_valid2(in_v[2]), .in_valid3(in_v[3]),
        .rc_data0(rc_d[7:0]), .rc_data1(rc_d[15:8]), .rc_data2(rc_d[23:16]), .rc_data3(rc_d[31:24]),
        .rc_valid0(rc_v[0]), .rc_valid1(rc_v[1]), .rc_valid2(rc_v[2]), .rc_valid3(rc_v[3]),
        .out_data0(od[7:0]), .out_data1(od[15:8]), .out_data2(od[23:16]), .out_data3(od[31:24]),
        .out_valid0(ov[0]), .out_valid1(ov[1]), .out_valid2(ov[2]), .out_valid3(ov[3]),
        .IDL(IDL), .ovf(ovf),
        .rc_count0(rcc[7:0]), .rc_count1(rcc[15:8]), .rc_count2(rcc[23:16]), .rc_count3(rcc[31:24])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            mq[l].delete();
            m_od[l] = 8'h00;
            m_rc[l] = 0;
        end
        m_ov  = '0;
        m_ovf = '0;
        m_idl = 1'b0;
        m_run = 0;
    endtask

    task automatic check_all();
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("out_valid%0d", l), 32'(ov[l]), 32'(m_ov[l]));
            chk($sformatf("out_data%0d", l), 32'(od[8*l+:8]), 32'(m_od[l]));
`ifdef RECIRC_CNT_EN
            chk($sformatf("rc_count%0d", l), 32'(rcc[8*l+:8]), 32'(m_rc[l] > 255 ? 255 : m_rc[l]));
`else
            chk($sformatf("rc_count%0d", l), 32'(rcc[8*l+:8]), 32'd0);
`endif
        end
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("IDL", 32'(IDL), 32'(m_idl));
    endtask

    // Drive one cycle of inputs, advance the model by the lane rules, check after the edge
    task automatic step(input logic [3:0] iv, input logic [31:0] id, input logic [3:0] rv, input logic [31:0] rd);
        logic quiet;
        in_v = iv; in_d = id; rc_v = rv; rc_d = rd;
        quiet = iv == 4'd0;
        for (int l = 0; l < 4; l++) if (mq[l].size() != 0) quiet = 1'b0;
        m_run = quiet ? m_run + 1 : 0;
        m_idl = m_run >= IDLE;
        for (int l = 0; l < 4; l++) begin
            m_ov[l] = 1'b1;
            if (rv[l]) begin
                m_od[l] = rd[8*l+:8];
                m_rc[l]++;
                if (iv[l]) begin
                    if (mq[l].size() < DEPTH) mq[l].push_back(id[8*l+:8]);
                    else m_ovf[l] = 1'b1;
                end
            end else if (mq[l].size() > 0) begin
                m_od[l] = mq[l].pop_front();
                if (iv[l]) mq[l].push_back(id[8*l+:8]);
            end else if (iv[l]) m_od[l] = id[8*l+:8];
            else m_ov[l] = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        in_v = '0; in_d = '0; rc_v = '0; rc_d = '0;
        model_reset();
        #2 reset_L = 1'b0;
        #1 check_all();
        @(posedge clk);
        @(posedge clk);
        #3 reset_L = 1'b1;
        repeat (4) step('0, '0, '0, '0);
        chk("idle_idl_high", 32'(IDL), 32'd1);

        step(4'b0001, 32'h0000_00A5, '0, '0);
        chk("bypass_data0", 32'(od[7:0]), 32'hA5);
        chk("bypass_idl_drop", 32'(IDL), 32'd0);

        step(4'b0010, 32'h0000_2200, 4'b0010, 32'h0000_1100);
        chk("collision_rc_first", 32'(od[15:8]), 32'h11);
        step('0, '0, '0, '0);
        chk("collision_ingress_second", 32'(od[15:8]), 32'h22);

        for (int i = 1; i <= 6; i++) begin
            step(4'b0100, 32'(i) << 16, 4'b0100, 32'h00CC_0000);
            if (i == 4) chk("ovf2_not_yet", 32'(ovf[2]), 32'd0);
        end
        chk("ovf2_set", 32'(ovf[2]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step('0, '0, '0, '0);
            chk("drain2_order", 32'(od[23:16]), 32'(i));
        end
        step('0, '0, '0, '0);
        chk("ovf2_sticky", 32'(ovf[2]), 32'd1);

        for (int i = 0; i < 4; i++) step(4'b1000, (32'h30 + 32'(i)) << 24, 4'b1000, 32'hEE00_0000);
        step(4'b1000, 32'h7700_0000, '0, '0);
        chk("full_pushpop_head", 32'(od[31:24]), 32'h30);
        chk("full_pushpop_no_ovf3", 32'(ovf[3]), 32'd0);
        repeat (3) step('0, '0, '0, '0);
        step('0, '0, '0, '0);
        chk("full_pushpop_exit77", 32'(od[31:24]), 32'h77);

        for (int i = 0; i < 3; i++) step(4'b0001, 32'h40 + 32'(i), 4'b0001, 32'h0000_0099);
        in_v = '0; in_d = '0; rc_v = '0; rc_d = '0;
        #2 reset_L = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #3 reset_L = 1'b1;
        repeat (4) step('0, '0, '0, '0);

        repeat (300) begin
            if ($urandom_range(0, 19) == 0) repeat (5) step('0, '0, '0, '0);
            else step(4'($urandom), $urandom, 4'($urandom) & 4'($urandom), $urandom);
        end
        repeat (100) step(4'($urandom), $urandom, 4'($urandom) | 4'($urandom), $urandom);
        repeat (270) step(4'($urandom), $urandom, 4'hF, $urandom);
        repeat (10) step('0, '0, '0, '0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
